// File: rtl/dff_response_checker.sv
// Response checker for a D_FF cell: synchronizes the observed pins, runs a golden flip-flop model and
// counts settled compares and mismatches. Define DFF_CHK_QBAR_EN to also check Qbar == ~Q on each compare.
module dff_response_checker #(
   parameter int SETTLE     = 2,
   parameter int NUM_CHECKS = 8,
   parameter int CNT_W      = 8
) (
   input  logic             C,
   input  logic             R,
   input  logic             start,
   input  logic             obs_D,
   input  logic             obs_C,
   input  logic             obs_nP,
   input  logic             obs_nR,
   input  logic             obs_Q,
   input  logic             obs_Qbar,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             illegal,
   output logic [CNT_W-1:0] chk_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             exp_Q
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WAIT, S_DONE} state_t;

   localparam logic [3:0]       SETTLE_V = 4'(SETTLE);
   localparam logic [CNT_W-1:0] NUM_V    = CNT_W'(NUM_CHECKS);
   localparam logic [CNT_W-1:0] ERR_MAX  = '1;

`ifdef DFF_CHK_QBAR_EN
   localparam int NOBS = 6;
   logic [NOBS-1:0] obs_vec;
   assign obs_vec = {obs_Qbar, obs_Q, obs_nR, obs_nP, obs_C, obs_D};
`else
   localparam int NOBS = 5;
   logic [NOBS-1:0] obs_vec;
   logic            unused_qbar;
   assign obs_vec     = {obs_Q, obs_nR, obs_nP, obs_C, obs_D};
   assign unused_qbar = obs_Qbar;
`endif

   logic [NOBS-1:0]  meta_q, meta_d, sync_q, sync_d;
   state_t           state_q, state_d;
   logic [3:0]       settle_q, settle_d;
   logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d, err_cnt_q, err_cnt_d;
   logic             exp_q_q, exp_q_d;
   logic             illegal_q, illegal_d;
   logic             prev_c_q, prev_c_d;

   logic s_d, s_c, s_np, s_nr, s_q;
   logic rise, event_hit, model_q, illegal_hit, mismatch;

   assign s_d  = sync_q[0];
   assign s_c  = sync_q[1];
   assign s_np = sync_q[2];
   assign s_nr = sync_q[3];
   assign s_q  = sync_q[4];
   assign rise = s_c & ~prev_c_q;

   always_comb begin
      meta_d   = obs_vec;
      sync_d   = meta_q;
      prev_c_d = s_c;
   end

   // Golden model: what exp_Q would become this cycle, and whether it is written at all.
   always_comb begin
      event_hit   = 1'b1;
      model_q     = exp_q_q;
      illegal_hit = 1'b0;
      if (!s_np && !s_nr) begin
         model_q     = 1'b1;
         illegal_hit = 1'b1;
      end else if (!s_np) begin
         model_q = 1'b1;
      end else if (!s_nr) begin
         model_q = 1'b0;
      end else if (rise) begin
         model_q = s_d;
      end else begin
         event_hit = 1'b0;
      end
   end

`ifdef DFF_CHK_QBAR_EN
   assign mismatch = (s_q != exp_q_q) | (sync_q[5] == s_q);
`else
   assign mismatch = (s_q != exp_q_q);
`endif

   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      chk_cnt_d = chk_cnt_q;
      err_cnt_d = err_cnt_q;
      exp_q_d   = exp_q_q;
      illegal_d = illegal_q;
      if (state_q != S_IDLE) begin
         exp_q_d   = model_q;
         illegal_d = illegal_q | illegal_hit;
      end
      case (state_q)
         S_IDLE: begin
            if (start) begin
               exp_q_d = s_q;
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            if (event_hit) begin
               settle_d = SETTLE_V;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            // Compare against the pre-event model value; a same-cycle event is applied afterwards.
            if (settle_q <= 4'd1) begin
               chk_cnt_d = chk_cnt_q + 1'b1;
               if (mismatch && (err_cnt_q != ERR_MAX))
                  err_cnt_d = err_cnt_q + 1'b1;
               if (chk_cnt_d == NUM_V) begin
                  settle_d = 4'd0;
                  state_d  = S_DONE;
               end else if (event_hit) begin
                  settle_d = SETTLE_V;
               end else begin
                  settle_d = 4'd0;
                  state_d  = S_ARMED;
               end
            end else if (event_hit) begin
               settle_d = SETTLE_V;
            end else begin
               settle_d = settle_q - 4'd1;
            end
         end
         S_DONE: begin
            if (start) begin
               chk_cnt_d = '0;
               err_cnt_d = '0;
               illegal_d = 1'b0;
               exp_q_d   = s_q;
               state_d   = S_ARMED;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge C) begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      if (R) begin
         state_q   <= S_IDLE;
         settle_q  <= 4'd0;
         chk_cnt_q <= '0;
         err_cnt_q <= '0;
         exp_q_q   <= 1'b0;
         illegal_q <= 1'b0;
         prev_c_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         chk_cnt_q <= chk_cnt_d;
         err_cnt_q <= err_cnt_d;
         exp_q_q   <= exp_q_d;
         illegal_q <= illegal_d;
         prev_c_q  <= prev_c_d;
      end
   end

   assign busy    = (state_q == S_ARMED) || (state_q == S_WAIT);
   assign done    = (state_q == S_DONE);
   assign pass    = done && (err_cnt_q == '0);
   assign illegal = illegal_q;
   assign chk_cnt = chk_cnt_q;
   assign err_cnt = err_cnt_q;
   assign exp_Q   = exp_q_q;

endmodule

// File: tb/tb_dff_response_checker.sv
// Directed bench for dff_response_checker (SETTLE=4, NUM_CHECKS=3); each task drives one scenario
// and checks hand-computed results one checker cycle at a time.
module tb_dff_response_checker;

   localparam int SETTLE     = 4;
   localparam int NUM_CHECKS = 3;
   localparam int CNT_W      = 8;

   logic             clk = 1'b0;
   logic             R = 1'b1;
   logic             start = 1'b0;
   logic             obs_D = 1'b0, obs_C = 1'b0, obs_nP = 1'b1, obs_nR = 1'b1;
   logic             obs_Q = 1'b0, obs_Qbar = 1'b1;
   logic             busy, done, pass, illegal, exp_Q;
   logic [CNT_W-1:0] chk_cnt, err_cnt;

   int vectors = 0;
   int miscompares = 0;

   dff_response_checker #(.SETTLE(SETTLE), .NUM_CHECKS(NUM_CHECKS), .CNT_W(CNT_W)) dut (
      .C(clk), .R(R), .start(start),
      .obs_D(obs_D), .obs_C(obs_C), .obs_nP(obs_nP), .obs_nR(obs_nR),
      .obs_Q(obs_Q), .obs_Qbar(obs_Qbar),
      .busy(busy), .done(done), .pass(pass), .illegal(illegal),
      .chk_cnt(chk_cnt), .err_cnt(err_cnt), .exp_Q(exp_Q)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Advance n checker edges, then settle 1 time unit past the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_obs(input logic d, input logic c, input logic np, input logic nr, input logic q);
      obs_D = d; obs_C = c; obs_nP = np; obs_nR = nr; obs_Q = q; obs_Qbar = ~q;
   endtask

   task automatic reset_dut();
      R = 1'b1;
      tick(4);
      R = 1'b0;
      tick(1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic test_reset();
      set_obs(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      reset_dut();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
      vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL reset_pass: got %b want 0", pass); end
      vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal: got %b want 0", illegal); end
      vectors++; if (chk_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_chk: got %0d want 0", chk_cnt); end
      vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
      vectors++; if (exp_Q !== 1'b0) begin miscompares++; $display("FAIL reset_expq: got %b want 0", exp_Q); end
      $display("test_reset: outputs checked after reset");
   endtask

   // Preset seed: one compare lands SETTLE+2 cycles after the start cycle.
   task automatic test_preset_seed();
      start = 1'b1;
      obs_nP = 1'b1;
      tick(1);
      start = 1'b0;
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL seed_busy: got %b want 1", busy); end
      vectors++; if (exp_Q !== 1'b1) begin miscompares++; $display("FAIL seed_expq: got %b want 1", exp_Q); end
      tick(SETTLE);
      vectors++; if (chk_cnt !== 8'd0) begin miscompares++; $display("FAIL seed_chk_early: got %0d want 0", chk_cnt); end
      tick(1);
      vectors++; if (chk_cnt !== 8'd1) begin miscompares++; $display("FAIL seed_chk: got %0d want 1", chk_cnt); end
      vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL seed_err: got %0d want 0", err_cnt); end
      $display("test_preset_seed: chk_cnt=%0d err_cnt=%0d", chk_cnt, err_cnt);
   endtask

   task automatic test_driver_sequence();
      set_obs(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      reset_dut();
      pulse_start();
      set_obs(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(10);
      vectors++; if (chk_cnt !== 8'd0) begin miscompares++; $display("FAIL drv_hold_reset_chk: got %0d want 0", chk_cnt); end
      obs_nR = 1'b1;
      tick(10);
      vectors++; if (chk_cnt !== 8'd1) begin miscompares++; $display("FAIL drv_rel_chk: got %0d want 1", chk_cnt); end
      vectors++; if (exp_Q !== 1'b0) begin miscompares++; $display("FAIL drv_rel_expq: got %b want 0", exp_Q); end
      set_obs(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(10);
      vectors++; if (chk_cnt !== 8'd2) begin miscompares++; $display("FAIL drv_rise1_chk: got %0d want 2", chk_cnt); end
      vectors++; if (exp_Q !== 1'b1) begin miscompares++; $display("FAIL drv_rise1_expq: got %b want 1", exp_Q); end
      obs_C = 1'b0;
      tick(10);
      vectors++; if (chk_cnt !== 8'd2) begin miscompares++; $display("FAIL drv_fall_chk: got %0d want 2", chk_cnt); end
      set_obs(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick(10);
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL drv_done: got %b want 1", done); end
      vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL drv_pass: got %b want 1", pass); end
      vectors++; if (chk_cnt !== 8'd3) begin miscompares++; $display("FAIL drv_chk: got %0d want 3", chk_cnt); end
      vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL drv_err: got %0d want 0", err_cnt); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL drv_busy: got %b want 0", busy); end
      $display("test_driver_sequence: done=%b pass=%b chk_cnt=%0d", done, pass, chk_cnt);
   endtask

   task automatic test_mismatch();
      set_obs(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      reset_dut();
      pulse_start();
      obs_nR = 1'b1;
      tick(10);
      vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL mis_first_err: got %0d want 0", err_cnt); end
      obs_D = 1'b1; obs_C = 1'b1;
      tick(10);
      vectors++; if (chk_cnt !== 8'd2) begin miscompares++; $display("FAIL mis_chk: got %0d want 2", chk_cnt); end
      vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL mis_err: got %0d want 1", err_cnt); end
      obs_C = 1'b0;
      tick(10);
      obs_D = 1'b0; obs_C = 1'b1;
      tick(10);
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL mis_done: got %b want 1", done); end
      vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL mis_pass: got %b want 0", pass); end
      vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL mis_err_final: got %0d want 1", err_cnt); end
      $display("test_mismatch: err_cnt=%0d pass=%b", err_cnt, pass);
   endtask

   task automatic test_illegal();
      set_obs(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      reset_dut();
      pulse_start();
      obs_nP = 1'b0; obs_Q = 1'b1; obs_Qbar = 1'b0;
      tick(4);
      vectors++; if (illegal !== 1'b1) begin miscompares++; $display("FAIL ill_set: got %b want 1", illegal); end
      vectors++; if (exp_Q !== 1'b1) begin miscompares++; $display("FAIL ill_expq: got %b want 1", exp_Q); end
      obs_nP = 1'b1; obs_nR = 1'b1;
      tick(10);
      vectors++; if (chk_cnt !== 8'd1) begin miscompares++; $display("FAIL ill_chk: got %0d want 1", chk_cnt); end
      vectors++; if (illegal !== 1'b1) begin miscompares++; $display("FAIL ill_sticky: got %b want 1", illegal); end
      obs_D = 1'b1; obs_C = 1'b1;
      tick(10);
      obs_C = 1'b0;
      tick(10);
      set_obs(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick(10);
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL ill_done: got %b want 1", done); end
      vectors++; if (illegal !== 1'b1) begin miscompares++; $display("FAIL ill_done_sticky: got %b want 1", illegal); end
      pulse_start();
      vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL ill_restart_clr: got %b want 0", illegal); end
      vectors++; if (chk_cnt !== 8'd0) begin miscompares++; $display("FAIL ill_restart_chk: got %0d want 0", chk_cnt); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ill_restart_busy: got %b want 1", busy); end
      vectors++; if (exp_Q !== 1'b0) begin miscompares++; $display("FAIL ill_restart_expq: got %b want 0", exp_Q); end
      $display("test_illegal: illegal=%b after restart", illegal);
   endtask

   // Second rise two cycles into WAIT: one compare, SETTLE cycles after the second rise.
   task automatic test_retrigger();
      obs_C = 1'b0;
      tick(6);
      set_obs(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(1);
      obs_C = 1'b0;
      tick(1);
      obs_C = 1'b1;
      tick(6);
      vectors++; if (chk_cnt !== 8'd0) begin miscompares++; $display("FAIL retrig_early: got %0d want 0", chk_cnt); end
      tick(1);
      vectors++; if (chk_cnt !== 8'd1) begin miscompares++; $display("FAIL retrig_chk: got %0d want 1", chk_cnt); end
      tick(10);
      vectors++; if (chk_cnt !== 8'd1) begin miscompares++; $display("FAIL retrig_single: got %0d want 1", chk_cnt); end
      vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL retrig_err: got %0d want 0", err_cnt); end
      $display("test_retrigger: chk_cnt=%0d", chk_cnt);
   endtask

   task automatic test_reset_mid_wait();
      obs_C = 1'b0;
      tick(6);
      obs_C = 1'b1;
      tick(3);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rmw_busy_before: got %b want 1", busy); end
      R = 1'b1;
      tick(1);
      R = 1'b0;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmw_busy: got %b want 0", busy); end
      vectors++; if (chk_cnt !== 8'd0) begin miscompares++; $display("FAIL rmw_chk: got %0d want 0", chk_cnt); end
      vectors++; if (exp_Q !== 1'b0) begin miscompares++; $display("FAIL rmw_expq: got %b want 0", exp_Q); end
      tick(10);
      vectors++; if (chk_cnt !== 8'd0) begin miscompares++; $display("FAIL rmw_no_compare: got %0d want 0", chk_cnt); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmw_idle: got %b want 0", busy); end
      $display("test_reset_mid_wait: busy=%b chk_cnt=%0d", busy, chk_cnt);
   endtask

`ifdef DFF_CHK_QBAR_EN
   task automatic test_qbar();
      set_obs(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      obs_Qbar = 1'b0;
      reset_dut();
      pulse_start();
      obs_nR = 1'b1;
      tick(10);
      vectors++; if (chk_cnt !== 8'd1) begin miscompares++; $display("FAIL qbar_chk: got %0d want 1", chk_cnt); end
      vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL qbar_err: got %0d want 1", err_cnt); end
      $display("test_qbar: err_cnt=%0d", err_cnt);
   endtask
`endif

   initial begin
      test_reset();
      test_preset_seed();
      test_driver_sequence();
      test_mismatch();
      test_illegal();
      test_retrigger();
      test_reset_mid_wait();
`ifdef DFF_CHK_QBAR_EN
      test_qbar();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dff_response_checker.md
Name: dff_response_checker

Overview:
- Synthesizable response checker for the D_FF cell. It is the observing end of the D_FF stimulus interface: the driver applies D/C/nP/nR, and this block watches those same signals plus Q/Qbar.
- Keeps an internal golden model of the flip-flop, compares the DUT against it after a settle delay, counts checks and mismatches, and reports pass/fail.
- Sits beside a D_FF instance on the lab bench or FPGA self-test, clocked by a free-running checker clock at least 4x faster than the DUT clock.

Parameters:
- SETTLE, 2: checker cycles between a detected DUT event and the compare; legal range 1..15.
- NUM_CHECKS, 8: compares performed before DONE; legal range 1..255.
- CNT_W, 8: width of the check and mismatch counters.

Ports:
- C  input  1  checker clock; all state updates on posedge.
- R  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; arms the checker.
- obs_D  input  1  DUT D input, observed.
- obs_C  input  1  DUT clock, observed and sampled as data.
- obs_nP  input  1  DUT active-low preset, observed.
- obs_nR  input  1  DUT active-low reset, observed.
- obs_Q  input  1  DUT Q output.
- obs_Qbar  input  1  DUT Qbar output.
- busy  output  1  high in ARMED or WAIT.
- done  output  1  high in DONE.
- pass  output  1  high in DONE when err_cnt == 0.
- illegal  output  1  sticky; set when nP=0 and nR=0 are sampled together.
- chk_cnt  output  CNT_W  number of compares completed.
- err_cnt  output  CNT_W  number of mismatches; saturates at all-ones.
- exp_Q  output  1  current golden-model value.

Behaviour:
- Input sampling: every obs_* input passes through a 2-flop synchronizer. The model and all compares use only the synchronized copies. Edge detect: rise = sync_C & ~prev_C.
- Reset: when R=1 at posedge C, the block goes to IDLE and forces busy=0, done=0, pass=0, illegal=0, chk_cnt=0, err_cnt=0, exp_Q=0, settle counter=0, prev_C=0. This applies in every state, including mid-WAIT; any pending compare is discarded.
- Golden model: updates every cycle in every state except IDLE. Priority order:
  - nP=0 and nR=0: exp_Q=1 and illegal is set.
  - nP=0: exp_Q=1.
  - nR=0: exp_Q=0.
  - rise: exp_Q=sync_D, with D taken from the same synchronized sample as the edge.
  - Otherwise exp_Q holds.
- Event: any cycle in which exp_Q is written, whether or not its value changes.
- IDLE: start=1 loads exp_Q from the current sync_Q (seed) and moves to ARMED. Otherwise stay in IDLE.
- ARMED: an event loads the settle counter with SETTLE and moves to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - An event during WAIT reloads the counter to SETTLE (retrigger) and does not count a compare.
  - When the counter reaches 0, compare sync_Q against exp_Q; chk_cnt increments; err_cnt increments on mismatch.
  - After the compare: if chk_cnt (post-increment) equals NUM_CHECKS, go to DONE; otherwise go to ARMED.
  - An event in the same cycle as the compare is applied to the model after the compare, and the FSM goes to WAIT with the counter loaded instead of to ARMED.
- DONE: outputs hold; start=1 clears both counters and illegal, reseeds exp_Q, and goes to ARMED.
- start is ignored in ARMED and WAIT.
- Counter widths: chk_cnt wraps only if NUM_CHECKS > 2^CNT_W-1, which is illegal. err_cnt saturates.

Optional Feature:
- Macro DFF_CHK_QBAR_EN.
- Defined: each compare also checks sync_Qbar == ~sync_Q. A failure counts as one mismatch per compare, combined with the Q check by OR, so the maximum is +1 per compare.
- Undefined: obs_Qbar is unused and Qbar errors are never counted.

Test Plan:
- Reset then start, with nP=0, nR=1, obs_Q=1 → exp_Q=1; one compare occurs SETTLE+2 cycles later; chk_cnt=1, err_cnt=0.
- Preset release then reset (nP=1, nR=0) with obs_Q=0; then D=1 and a C rise with obs_Q=1; then D=0 and a C rise with obs_Q=0 (matches the D_FF driver sequence); NUM_CHECKS=3 → done=1, pass=1, chk_cnt=3.
- C rise with D=1 but obs_Q held at 0 → err_cnt=1, pass=0 at DONE.
- nP=0 and nR=0 together for 1 DUT cycle → illegal=1, exp_Q=1; illegal stays set until R or a restart from DONE.
- Second C rise inside the WAIT window → only one compare is counted, taken SETTLE cycles after the second event.
- R asserted mid-WAIT → next cycle busy=0, chk_cnt=0, and no compare ever occurs. With DFF_CHK_QBAR_EN defined, forcing obs_Qbar=obs_Q gives err_cnt=1 per compare.
